// File: rtl/bit_sync_down_counter.sv
// Loadable N-bit down counter with registered one-cycle terminal-count pulse.
// Optional periodic auto-reload is enabled by defining DOWN_COUNTER_RELOAD_EN.
module bit_sync_down_counter #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [N-1:0] D,
  input  logic         CE,
`ifdef DOWN_COUNTER_RELOAD_EN
  input  logic         RELOAD,
`endif
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         BUSY
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic [N-1:0] rld, rld_nxt;
  logic         tc, tc_nxt;
  logic         reload_active;

`ifdef DOWN_COUNTER_RELOAD_EN
  assign reload_active = RELOAD;
`else
  assign reload_active = 1'b0;
`endif

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      state <= IDLE;
      cnt   <= '0;
      rld   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rld   <= rld_nxt;
      tc    <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;
    if (LOAD) begin
      // A zero load expires immediately instead of entering RUN.
      cnt_nxt = D;
      if (D != '0) begin
        rld_nxt   = D;
        state_nxt = RUN;
      end else begin
        tc_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    end else if (state == RUN && CE) begin
      if (cnt > N'(1)) begin
        cnt_nxt = cnt - N'(1);
      end else begin
        // Expiry from 1; the <= 1 test also keeps a stray 0 from wrapping.
        tc_nxt = 1'b1;
        if (reload_active) begin
          cnt_nxt = rld;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
    end
  end

  assign Q    = cnt;
  assign TC   = tc;
  assign BUSY = (state == RUN);

endmodule
